// File: rtl/ysyx_22050078_mc_ctrl_if.sv
// Fetch request/response bus between the multicycle sequencer (master) and
// instruction memory (slave).
interface ysyx_22050078_mc_ctrl_if #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [PC_WIDTH-1:0]   if_addr;
  logic                  if_resp_valid;
  logic [INST_WIDTH-1:0] if_resp_inst;
  logic                  if_resp_err;

  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_resp_inst, if_resp_err
  );

  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_resp_inst, if_resp_err
  );
endinterface

// File: rtl/ysyx_22050078_mc_ctrl.sv
// Multicycle core sequencer: owns PC/IR, fetches over valid/ready, steps FETCH->DECODE->EXEC->WB.
// Optional macro FETCH_TIMEOUT_EN adds a FETCH_WAIT watchdog (fault cause 3).
//
// state        | meaning
// S_FETCH_REQ  | fetch request valid, waiting for memory accept
// S_FETCH_WAIT | request accepted, waiting for response
// S_DECODE     | one-cycle id_en
// S_EXEC       | ex_en held until ex_done
// S_WB         | wb_en/commit, PC update
// S_HALT       | ebreak retired; leave by reset only
// S_FAULT      | misaligned target / bus error / timeout; leave by reset only
module ysyx_22050078_mc_ctrl #(
  parameter int                  PC_WIDTH      = 64,
  parameter int                  INST_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = PC_WIDTH'(64'h8000_0000),
  parameter int                  FETCH_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050078_mc_ctrl_if.master     fbus,
  output logic [PC_WIDTH-1:0]         pc,
  output logic [INST_WIDTH-1:0]       inst,
  output logic                        id_en,
  output logic                        ex_en,
  input  logic                        ex_done,
  input  logic                        br_taken,
  input  logic [PC_WIDTH-1:0]         br_target,
  input  logic                        halt_req,
  output logic                        wb_en,
  output logic                        commit,
  output logic [63:0]                 instret,
  output logic                        halted,
  output logic                        fault,
  output logic [1:0]                  fault_cause
);

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [63:0]           instret_q, instret_d;
  logic                  br_q, br_d;
  logic [PC_WIDTH-1:0]   tgt_q, tgt_d;
  logic                  halt_q, halt_d;
  logic [1:0]            cause_q, cause_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
      br_q      <= 1'b0;
      tgt_q     <= '0;
      halt_q    <= 1'b0;
      cause_q   <= 2'd0;
`ifdef FETCH_TIMEOUT_EN
      tmr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      br_q      <= br_d;
      tgt_q     <= tgt_d;
      halt_q    <= halt_d;
      cause_q   <= cause_d;
`ifdef FETCH_TIMEOUT_EN
      tmr_q     <= tmr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    br_d      = br_q;
    tgt_d     = tgt_q;
    halt_d    = halt_q;
    cause_d   = cause_q;
`ifdef FETCH_TIMEOUT_EN
    tmr_d     = tmr_q;
`endif
    case (state_q)
      S_FETCH_REQ: begin
        if (fbus.if_req_ready) begin
          state_d = S_FETCH_WAIT;
`ifdef FETCH_TIMEOUT_EN
          tmr_d   = TW'(FETCH_TIMEOUT - 1);
`endif
        end
      end
      S_FETCH_WAIT: begin
        // a response in the watchdog's terminal cycle still wins
        if (fbus.if_resp_valid) begin
          if (fbus.if_resp_err) begin
            state_d = S_FAULT;
            cause_d = 2'd2;
          end else begin
            inst_d  = fbus.if_resp_inst;
            state_d = S_DECODE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmr_q == '0) begin
          state_d = S_FAULT;
          cause_d = 2'd3;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ex_done) begin
          if (br_taken && (br_target[1:0] != 2'b00)) begin
            state_d = S_FAULT;
            cause_d = 2'd1;
          end else begin
            br_d    = br_taken;
            tgt_d   = br_target;
            halt_d  = halt_req;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        instret_d = instret_q + 64'd1;
        pc_d      = br_q ? tgt_q : pc_q + PC_WIDTH'(4);
        state_d   = halt_q ? S_HALT : S_FETCH_REQ;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // strobes are forced low while reset is held
  assign fbus.if_req_valid = rst & (state_q == S_FETCH_REQ);
  assign fbus.if_addr      = pc_q;
  assign id_en             = rst & (state_q == S_DECODE);
  assign ex_en             = rst & (state_q == S_EXEC);
  assign wb_en             = rst & (state_q == S_WB);
  assign commit            = wb_en;
  assign pc                = pc_q;
  assign inst              = inst_q;
  assign instret           = instret_q;
  assign halted            = (state_q == S_HALT);
  assign fault             = (state_q == S_FAULT);
  assign fault_cause       = cause_q;

endmodule
